// File: rtl/div_pkg.sv
// Shared widths, FSM state type and constants for the 32/16 divider.
// Imported by div_step and seq_divider_32by16.
package div_pkg;

   localparam int DIVIDEND_W = 32;
   localparam int DIVISOR_W  = 16;
   localparam int CNT_W      = 5;

   localparam logic [DIVIDEND_W-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare the 17-bit trial value with the
// divisor and subtract when it fits, yielding the next quotient bit.
module div_step
   import div_pkg::*;
(
   input  logic [DIVISOR_W:0]   i_t,
   input  logic [DIVISOR_W-1:0] i_d,
   output logic [DIVISOR_W:0]   o_r,
   output logic                 o_qbit
);

   logic [DIVISOR_W:0] w_d_ext;
   logic [DIVISOR_W:0] w_diff;

   assign w_d_ext = {1'b0, i_d};
   assign w_diff  = i_t - w_d_ext;

   // keep the difference only when the divisor fits into the trial value
   always_comb begin
      o_qbit = 1'b0;
      o_r    = i_t;
      if (i_t >= w_d_ext) begin
         o_qbit = 1'b1;
         o_r    = w_diff;
      end
   end

endmodule

// File: rtl/seq_divider_32by16.sv
// Sequential unsigned restoring divider, 32-bit by 16-bit, 1 bit/clock.
// Option: DIV_ZERO_EARLY_EN finishes a zero-divisor request immediately.
module seq_divider_32by16
   import div_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   div_state_t r_state;
   div_state_t w_state_next;

   logic [DIVIDEND_W-1:0] r_q;
   logic [DIVISOR_W:0]    r_r;
   logic [DIVISOR_W-1:0]  r_d;
   logic [CNT_W-1:0]      r_cnt;
   logic [DIVIDEND_W-1:0] r_quot;
   logic [DIVISOR_W-1:0]  r_rem;

   logic [DIVISOR_W:0]    w_t;
   logic [DIVISOR_W:0]    w_r_next;
   logic                  w_qbit;
   logic [DIVIDEND_W-1:0] w_q_next;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_early_zero;
   logic                  w_unused;

   // the partial remainder never exceeds the divisor, so its top bit
   // only exists to hold the trial value during the compare
   assign w_unused = r_r[DIVISOR_W];

   assign w_t      = {r_r[DIVISOR_W-1:0], r_q[DIVIDEND_W-1]};
   assign w_q_next = {r_q[DIVIDEND_W-2:0], w_qbit};
   assign w_accept = (r_state == IDLE) && start;
   assign w_last   = (r_cnt == {CNT_W{1'b1}});

`ifdef DIV_ZERO_EARLY_EN
   assign w_early_zero = (divisor == '0);
`else
   assign w_early_zero = 1'b0;
`endif

   div_step u_step (
      .i_t    (w_t),
      .i_d    (r_d),
      .o_r    (w_r_next),
      .o_qbit (w_qbit)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // next-state logic: IDLE -> RUN -> DONE -> IDLE
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_state_next = w_early_zero ? DONE : RUN;
            end
         end
         RUN: begin
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // operand latch, shift registers, counter and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q    <= '0;
         r_r    <= '0;
         r_d    <= '0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
      end else if (w_accept) begin
         r_d   <= divisor;
         r_q   <= dividend;
         r_r   <= '0;
         r_cnt <= '0;
         if (w_early_zero) begin
            r_quot <= DIV_ZERO_Q;
            r_rem  <= dividend[DIVISOR_W-1:0];
         end
      end else if (r_state == RUN) begin
         r_q   <= w_q_next;
         r_r   <= w_r_next;
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_quot <= w_q_next;
            r_rem  <= w_r_next[DIVISOR_W-1:0];
         end
      end
   end

`ifdef DIV_ZERO_EARLY_EN
   logic r_dbz;

   // zero-divisor flag follows every accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dbz <= 1'b0;
      end else if (w_accept) begin
         r_dbz <= w_early_zero;
      end
   end

   assign div_by_zero = r_dbz;
`else
   assign div_by_zero = 1'b0;
`endif

   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);
   assign quotient  = r_quot;
   assign remainder = r_rem;

endmodule

// File: tb/tb_seq_divider_32by16.sv
// Directed-vector bench for seq_divider_32by16.
// Expectations are hand-computed; zero-divisor timing follows DIV_ZERO_EARLY_EN.
module tb_seq_divider_32by16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;

`ifdef DIV_ZERO_EARLY_EN
   localparam int ZLAT = 0;
   localparam logic [31:0] ZDBZ = 32'd1;
`else
   localparam int ZLAT = 32;
   localparam logic [31:0] ZDBZ = 32'd0;
`endif

   seq_divider_32by16 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [31:0] dd, input logic [15:0] dv);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int inj, output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (lat == inj) begin
            start    = 1'b1;
            dividend = 32'd99;
            divisor  = 16'd9;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         lat++;
      end
      if (lat >= 40) check("timeout", 32'd1, 32'd0);
   endtask

   int lat;
   int c0;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_q", quotient, 32'd0);
      check("rst_r", {16'd0, remainder}, 32'd0);
      check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      launch(32'h0000_FFFE, 16'h00FF);
      check("t1_busy", {31'd0, busy}, 32'd1);
      wait_done(-1, lat);
      check("t1_lat", lat, 32'd32);
      check("t1_q", quotient, 32'h0000_0100);
      check("t1_r", {16'd0, remainder}, 32'h0000_00FE);
      check("t1_dbz", {31'd0, div_by_zero}, 32'd0);
      @(posedge clk);
      #1;
      check("t1_idle", {30'd0, busy, done}, 32'd0);

      launch(32'hFFFE_0001, 16'hFFFF);
      wait_done(-1, lat);
      check("t2_lat", lat, 32'd32);
      check("t2_q", quotient, 32'h0000_FFFF);
      check("t2_r", {16'd0, remainder}, 32'd0);
      @(posedge clk);
      #1;

      launch(32'h1234_5678, 16'h0000);
      wait_done(-1, lat);
      check("t3_lat", lat, ZLAT);
      check("t3_q", quotient, 32'hFFFF_FFFF);
      check("t3_r", {16'd0, remainder}, 32'h0000_5678);
      check("t3_dbz", {31'd0, div_by_zero}, ZDBZ);
      @(posedge clk);
      #1;

      launch(32'd5, 16'd7);
      wait_done(-1, lat);
      check("t4a_lat", lat, 32'd32);
      check("t4a_q", quotient, 32'd0);
      check("t4a_r", {16'd0, remainder}, 32'd5);
      check("t4a_dbz", {31'd0, div_by_zero}, 32'd0);
      @(posedge clk);
      #1;
      launch(32'd100, 16'd7);
      repeat (10) @(posedge clk);
      #1;
      check("t4b_busy", {31'd0, busy}, 32'd1);
      check("t4b_hold_r", {16'd0, remainder}, 32'd5);
      wait_done(-1, lat);
      check("t4b_lat", lat + 10, 32'd32);
      check("t4b_q", quotient, 32'd14);
      check("t4b_r", {16'd0, remainder}, 32'd2);
      @(posedge clk);
      #1;

      c0 = done_cnt;
      launch(32'd20, 16'd3);
      wait_done(5, lat);
      check("t5_lat", lat, 32'd32);
      check("t5_q", quotient, 32'd6);
      check("t5_r", {16'd0, remainder}, 32'd2);
      repeat (40) @(posedge clk);
      #1;
      check("t5_ndone", done_cnt - c0, 32'd1);
      check("t5_busy", {31'd0, busy}, 32'd0);

      launch(32'd1000, 16'd10);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_done", {31'd0, done}, 32'd0);
      check("t6_q", quotient, 32'd0);
      check("t6_r", {16'd0, remainder}, 32'd0);
      check("t6_dbz", {31'd0, div_by_zero}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      c0 = done_cnt;
      repeat (40) @(posedge clk);
      #1;
      check("t6_ndone", done_cnt - c0, 32'd0);
      check("t6_idle", {31'd0, busy}, 32'd0);
      launch(32'd1000, 16'd10);
      wait_done(-1, lat);
      check("t6_lat", lat, 32'd32);
      check("t6_q2", quotient, 32'd100);
      check("t6_r2", {16'd0, remainder}, 32'd0);
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
